// File: rtl/btn_evt_pkg.sv
// Shared event codes and hold-tracker state encodings
// for the button event arbiter.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_LONG    = 2'b01,
        EVT_REPEAT  = 2'b10,
        EVT_RELEASE = 2'b11
    } evt_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_LONG = 2'b10
    } trk_state_t;

endpackage

// File: rtl/btn_hold_tracker.sv
// Per-button hold tracker: edge detect, IDLE/HELD/LONG FSM and hold counter.
// emit/kind are decoded from current state so the slot is written on the same edge.
module btn_hold_tracker #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       emit,
    output logic [1:0] kind
);
    import btn_evt_pkg::*;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    trk_state_t       state;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;
    evt_kind_t        kind_c;

    assign rise = btn & ~prev;
    assign fall = ~btn & prev;
    assign kind = kind_c;

    // A fall always wins over a count match on the same edge.
    always_comb begin
        emit   = 1'b0;
        kind_c = EVT_PRESS;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    emit   = 1'b1;
                    kind_c = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    emit   = 1'b1;
                    kind_c = EVT_RELEASE;
                end else if (cnt == LONG_LAST) begin
                    emit   = 1'b1;
                    kind_c = EVT_LONG;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    emit   = 1'b1;
                    kind_c = EVT_RELEASE;
                end else if (cnt == REP_LAST) begin
                    emit   = 1'b1;
                    kind_c = EVT_REPEAT;
                end
            end
            default: begin
                emit   = 1'b0;
                kind_c = EVT_PRESS;
            end
        endcase
    end

    // prev follows the button even in reset, so a held button gives no PRESS.
    always_ff @(posedge clk) begin
        prev <= btn;
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rise) state <= ST_HELD;
                end
                ST_HELD: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state <= ST_LONG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into PRESS/LONG/REPEAT/RELEASE events
// delivered one at a time through a round-robin arbitrated valid/ready port.
module button_event_arbiter #(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26,
    localparam int BW           = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_db,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [BW-1:0]    evt_btn,
    output logic [1:0]       evt_kind,
    output logic             drop
);
    import btn_evt_pkg::*;

    logic [N_BTN-1:0] emit;
    logic [1:0]       emit_kind [N_BTN];
    logic [N_BTN-1:0] slot_v;
    logic [1:0]       slot_k [N_BTN];
    logic [BW-1:0]    ptr;

    logic             loadable;
    logic             found;
    logic             take;
    logic [BW-1:0]    grant;
    logic             lost;
    int               idx;

    for (genvar g = 0; g < N_BTN; g++) begin : g_trk
        btn_hold_tracker #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_trk (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_db[g]),
            .emit (emit[g]),
            .kind (emit_kind[g])
        );
    end

    // Round-robin scan starting just after the last granted button.
    always_comb begin
        loadable = !evt_valid || evt_ready;
        found    = 1'b0;
        grant    = '0;
        idx      = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(ptr) + k) % N_BTN;
            if (!found && slot_v[idx]) begin
                found = 1'b1;
                grant = BW'(idx);
            end
        end
        take = loadable && found;
    end

    always_comb begin
        lost = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (emit[i] && slot_v[i] && !(take && grant == BW'(i)))
                lost = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_v    <= '0;
            for (int i = 0; i < N_BTN; i++) slot_k[i] <= EVT_PRESS;
            ptr       <= BW'(N_BTN - 1);
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_kind  <= EVT_PRESS;
            drop      <= 1'b0;
        end else begin
            // A slot freed by the arbiter on this edge can accept a new event.
            for (int i = 0; i < N_BTN; i++) begin
                if (emit[i] && (!slot_v[i] || (take && grant == BW'(i)))) begin
                    slot_v[i] <= 1'b1;
                    slot_k[i] <= emit_kind[i];
                end else if (take && grant == BW'(i)) begin
                    slot_v[i] <= 1'b0;
                end
            end
            drop <= lost;
            if (loadable) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_btn   <= grant;
                    evt_kind  <= slot_k[grant];
                    ptr       <= grant;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule
